fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request at a time feeding a DEPTH-entry
// FIFO of {instruction, pc} pairs, with redirect flush and stale-response discard.
module fetch_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectPC,
  output logic                  MemReq,
  output logic [DATA_WIDTH-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic [DATA_WIDTH-1:0] MemRData,
  output logic                  InstrValid,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  input  logic                  InstrReady
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StFetch,
    StFull,
    StDiscard
  } state_e;

  state_e                stateQ, stateD;
  logic [DATA_WIDTH-1:0] fetchPcQ, fetchPcD;
  logic [DATA_WIDTH-1:0] staleAddrQ, staleAddrD;
  logic [CntW-1:0]       countQ, countD;
  logic [PtrW-1:0]       wrPtrQ, wrPtrD;
  logic [PtrW-1:0]       rdPtrQ, rdPtrD;

  logic [DATA_WIDTH-1:0] instrMem [DEPTH];
  logic [DATA_WIDTH-1:0] pcMem    [DEPTH];

  logic                  headValid;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic [DATA_WIDTH-1:0] redirectTarget;
  logic [DATA_WIDTH-1:0] headPc;

  assign headValid      = (countQ != '0);
  assign redirectTarget = RedirectPC & ~DATA_WIDTH'(3);

  // Only FETCH can accept a returned word; a coincident redirect drops it.
  assign push  = (stateQ == StFetch) && MemAck && !Redirect;
  assign pop   = headValid && InstrReady && !Redirect;
  assign flush = Redirect && (stateQ != StDiscard);

  always_comb begin
    countD = countQ;
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    if (flush) begin
      countD = '0;
      wrPtrD = '0;
      rdPtrD = '0;
    end else begin
      countD = countQ + CntW'(push) - CntW'(pop);
      if (push) wrPtrD = wrPtrQ + PtrW'(1);
      if (pop)  rdPtrD = rdPtrQ + PtrW'(1);
    end
  end

  always_comb begin
    stateD     = stateQ;
    fetchPcD   = fetchPcQ;
    staleAddrD = staleAddrQ;
    unique case (stateQ)
      StFetch: begin
        if (Redirect) begin
          fetchPcD = redirectTarget;
          // The in-flight request cannot be withdrawn; hold its address until it completes.
          if (!MemAck) begin
            stateD     = StDiscard;
            staleAddrD = fetchPcQ;
          end
        end else if (MemAck) begin
          fetchPcD = fetchPcQ + DATA_WIDTH'(4);
          if (countD == CntFull) stateD = StFull;
        end
      end
      StFull: begin
        if (Redirect) begin
          fetchPcD = redirectTarget;
          stateD   = StFetch;
        end else if (countD < CntFull) begin
          stateD = StFetch;
        end
      end
      StDiscard: begin
        if (Redirect) fetchPcD = redirectTarget;
        if (MemAck)   stateD   = StFetch;
      end
      default: stateD = StFetch;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stateQ     <= StFetch;
      fetchPcQ   <= RESET_PC;
      staleAddrQ <= '0;
      countQ     <= '0;
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
    end else begin
      stateQ     <= stateD;
      fetchPcQ   <= fetchPcD;
      staleAddrQ <= staleAddrD;
      countQ     <= countD;
      wrPtrQ     <= wrPtrD;
      rdPtrQ     <= rdPtrD;
    end
  end

  // Storage needs no reset: every read is gated by headValid.
  always_ff @(posedge CLK) begin
    if (push) begin
      instrMem[wrPtrQ] <= MemRData;
      pcMem[wrPtrQ]    <= fetchPcQ;
    end
  end

  assign MemReq  = RST && (stateQ != StFull);
  assign MemAddr = (stateQ == StDiscard) ? staleAddrQ : fetchPcQ;

  assign headPc     = pcMem[rdPtrQ];
  assign InstrValid = headValid;
  assign InstrF     = headValid ? instrMem[rdPtrQ] : '0;
  assign PCF        = headValid ? headPc : '0;
  assign PCPlus4F   = headValid ? (headPc + DATA_WIDTH'(4)) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model, per-cycle compare, latency-configurable
// memory responder and directed scenarios with literal expectations.
module tb_fetch_queue;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] ResetPc = 32'h0;

  logic        CLK, RST, Redirect, InstrReady, MemAck, MemReq, InstrValid;
  logic [31:0] RedirectPC, MemAddr, MemRData, InstrF, PCF, PCPlus4F;

  int checks = 0;
  int errors = 0;

  int unsigned memLat;
  logic        ackForce;
  int unsigned reqCnt;

  logic [31:0] mq[$];
  logic [31:0] mPc, mStale;
  logic        mDisc;

  fetch_queue #(
    .DATA_WIDTH(32),
    .DEPTH     (Depth),
    .RESET_PC  (ResetPc)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .MemReq    (MemReq),
    .MemAddr   (MemAddr),
    .MemAck    (MemAck),
    .MemRData  (MemRData),
    .InstrValid(InstrValid),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .InstrReady(InstrReady)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge CLK);
    #1;
    InstrReady = rdy;
    Redirect   = redir;
    RedirectPC = tgt;
  endtask

  // Memory: acks on the memLat-th cycle a request has been held; ackForce injects stray acks.
  always @(posedge CLK or negedge RST) begin
    if (!RST) reqCnt = 0;
    else if (MemReq && !MemAck) reqCnt = reqCnt + 1;
    else reqCnt = 0;
  end

  always @(negedge CLK) begin
    #3;
    MemAck   = (MemReq && (reqCnt + 1 >= memLat)) || ackForce;
    MemRData = img(MemAddr);
  end

  // Reference model: the queue holds pcs; a request is open whenever discarding or not full.
  always @(posedge CLK or negedge RST) begin
    logic reqNow, ackEff;
    if (!RST) begin
      mq.delete();
      mPc    = ResetPc;
      mDisc  = 1'b0;
      mStale = '0;
    end else begin
      reqNow = mDisc || (mq.size() < Depth);
      ackEff = reqNow && MemAck;
      if (mDisc) begin
        if (ackEff) mDisc = 1'b0;
        if (Redirect) mPc = RedirectPC & ~32'h3;
      end else if (Redirect) begin
        mq.delete();
        if (reqNow && !ackEff) begin
          mDisc  = 1'b1;
          mStale = mPc;
        end
        mPc = RedirectPC & ~32'h3;
      end else begin
        if ((mq.size() != 0) && InstrReady) void'(mq.pop_front());
        if (ackEff) begin
          mq.push_back(mPc);
          mPc = mPc + 32'd4;
        end
      end
    end
  end

  always @(negedge CLK) begin
    logic        expValid, expReq;
    logic [31:0] head;
    if (!RST) begin
      check("rst_InstrValid", InstrValid, 0);
      check("rst_MemReq", MemReq, 0);
      check("rst_PCF", PCF, 0);
      check("rst_InstrF", InstrF, 0);
      check("rst_PCPlus4F", PCPlus4F, 0);
    end else begin
      expValid = (mq.size() != 0);
      head     = expValid ? mq[0] : 32'h0;
      expReq   = mDisc || (mq.size() < Depth);
      check("InstrValid", InstrValid, expValid);
      check("PCF", PCF, expValid ? head : 32'h0);
      check("InstrF", InstrF, expValid ? img(head) : 32'h0);
      check("PCPlus4F", PCPlus4F, expValid ? head + 32'd4 : 32'h0);
      check("MemReq", MemReq, expReq);
      if (expReq) check("MemAddr", MemAddr, mDisc ? mStale : mPc);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    CLK = 0; RST = 0; Redirect = 0; RedirectPC = 0; InstrReady = 1;
    MemAck = 0; MemRData = 0; memLat = 1; ackForce = 0;

    // Reset and zero-wait streaming
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("lit_rst_valid", InstrValid, 0);
    check("lit_rst_req", MemReq, 0);
    RST = 1;
    #1;
    check("lit_boot_req", MemReq, 1);
    check("lit_boot_addr", MemAddr, ResetPc);
    tick(1, 0, 0);
    check("lit_first_valid", InstrValid, 1);
    check("lit_first_pcf", PCF, 32'h0);
    check("lit_first_instr", InstrF, img(32'h0));
    tick(1, 0, 0);
    check("lit_second_pcf", PCF, 32'h4);
    check("lit_second_plus4", PCPlus4F, 32'h8);
    tick(1, 0, 0);
    check("lit_third_pcf", PCF, 32'h8);
    repeat (5) tick(1, 0, 0);

    // Fill with decode stalled, stray acks while full, then drain
    tick(0, 1, 32'h0);
    repeat (6) tick(0, 0, 0);
    ackForce = 1;
    repeat (4) tick(0, 0, 0);
    ackForce = 0;
    check("lit_full_req", MemReq, 0);
    check("lit_full_head", PCF, 32'h0);
    tick(1, 0, 0);
    check("lit_drain0", PCF, 32'h0);
    tick(1, 0, 0);
    check("lit_drain1", PCF, 32'h4);
    check("lit_reissue_req", MemReq, 1);
    check("lit_reissue_addr", MemAddr, 32'h10);
    tick(1, 0, 0);
    check("lit_drain2", PCF, 32'h8);
    tick(1, 0, 0);
    check("lit_drain3", PCF, 32'hC);

    // Slow memory, redirect in the second cycle of request 0x8
    memLat = 3;
    tick(1, 1, 32'h0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1, 0, 0);
      if (MemReq && MemAddr == 32'h8) found = 1;
    end
    check("req8_seen", found, 1);
    tick(1, 1, 32'h106);
    tick(1, 0, 0);
    check("lit_discard_addr", MemAddr, 32'h8);
    check("lit_discard_empty", InstrValid, 0);
    tick(1, 0, 0);
    check("lit_redir_addr", MemAddr, 32'h104);
    check("lit_redir_empty", InstrValid, 0);

    // Redirect coincident with ack and pop
    memLat = 1;
    repeat (4) tick(1, 0, 0);
    check("lit_pre_valid", InstrValid, 1);
    tick(1, 1, 32'h400);
    tick(1, 0, 0);
    check("lit_coinc_valid", InstrValid, 0);
    check("lit_coinc_addr", MemAddr, 32'h400);
    tick(1, 0, 0);
    check("lit_coinc_pcf", PCF, 32'h400);

    // Two redirects during one discard
    memLat = 100;
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 32'h200);
    tick(1, 1, 32'h300);
    tick(1, 0, 0);
    memLat = 1;
    tick(1, 0, 0);
    check("lit_last_redir_addr", MemAddr, 32'h300);
    tick(1, 0, 0);
    check("lit_last_redir_pcf", PCF, 32'h300);

    // Reset while full
    repeat (8) tick(0, 0, 0);
    check("lit_full2_req", MemReq, 0);
    check("lit_full2_valid", InstrValid, 1);
    RST = 0;
    #1;
    check("lit_async_valid", InstrValid, 0);
    check("lit_async_req", MemReq, 0);
    check("lit_async_pcf", PCF, 0);
    check("lit_async_instr", InstrF, 0);
    check("lit_async_plus4", PCPlus4F, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    RST = 1;
    #1;
    check("lit_restart_req", MemReq, 1);
    check("lit_restart_addr", MemAddr, ResetPc);
    tick(1, 0, 0);
    check("lit_restart_pcf", PCF, ResetPc);
    repeat (3) tick(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
